key_bank: RTL and testbench

Parametrised multi-channel push-button front end. It is the successor to the single-key 10 ms capture block. Each channel synchronises a raw pad input, debounces it against a shared sample tick, and emits one-cycle event pulses:
- press
- release
- long-press
- auto-repeat

It sits between board button pads and control logic such as UDP test triggers and mode selects, replacing per-key instances with one bank.

---
 rtl/key_pkg.sv | 29 ++
 rtl/key_chan.sv | 114 +++++++++++
 rtl/key_bank.sv | 70 +++++++
 tb/tb_key_bank.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// key_pkg : shared types and parameter helpers for the key_bank button front end
// Revision: 1.0
// ============================================================================
package key_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PCHK = 2'd1,
    HELD = 2'd2,
    RCHK = 2'd3
  } key_state_e;

  function automatic int tick_cycles(input int clk_freq, input int sample_ms);
    return clk_freq / 1000 * sample_ms;
  endfunction

  function automatic bit params_legal(input int clk_freq, input int num_keys,
                                      input int sample_ms, input int long_ms,
                                      input int repeat_ms);
    if (sample_ms < 1) return 1'b0;
    return (num_keys >= 1) && (num_keys <= 32) &&
           (tick_cycles(clk_freq, sample_ms) >= 2) &&
           (long_ms / sample_ms >= 1) && (repeat_ms / sample_ms >= 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_chan.sv
`default_nettype none
// ============================================================================
// key_chan : one button channel - synchroniser, debounce FSM, hold counter
// Revision: 1.0
// ============================================================================
module key_chan
  import key_pkg::*;
#(
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 20,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic tick_i,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int              HOLD_W    = $clog2(LONG_TICKS + REPEAT_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_RPT  = HOLD_W'(LONG_TICKS + REPEAT_TICKS);

  logic [1:0]        sync_q;
  logic              act;
  key_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
  logic              press_q, press_d, release_q, release_d;
  logic              long_q, long_d, repeat_q, repeat_d;

  // Synchroniser idles at the released pad level so reset never looks like a press
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) sync_q <= {2{ACTIVE_LOW}};
    else         sync_q <= {sync_q[0], key_i};
  end

  assign act = sync_q[1] ^ ACTIVE_LOW;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tick_i) begin
      case (state_q)
        IDLE:    if (act) state_d = PCHK;
        PCHK:    state_d = act ? HELD : IDLE;
        HELD:    if (!act) state_d = RCHK;
        RCHK:    state_d = act ? HELD : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Hold keeps counting through a one-tick bounce so long/repeat timing is preserved
  always_comb begin
    hold_inc  = hold_q + HOLD_W'(1);
    hold_d    = hold_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    if (tick_i) begin
      case (state_q)
        PCHK: begin
          if (act) begin
            press_d = 1'b1;
            hold_d  = '0;
          end
        end
        HELD, RCHK: begin
          if (state_q == RCHK && !act) begin
            release_d = 1'b1;
            hold_d    = '0;
          end else if (hold_inc == HOLD_RPT) begin
            repeat_d = 1'b1;
            hold_d   = HOLD_LONG;
          end else begin
            hold_d = hold_inc;
            long_d = (hold_inc == HOLD_LONG);
          end
        end
        default: ;
      endcase
    end
  end

  assign level_o   = (state_q == HELD) || (state_q == RCHK);
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;

endmodule
`default_nettype wire

// File: rtl/key_bank.sv
`default_nettype none
// ============================================================================
// key_bank : multi-channel debounced push-button front end with shared tick
// Revision: 1.0
// ============================================================================
module key_bank
  import key_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int NUM_KEYS   = 4,
  parameter int SAMPLE_MS  = 10,
  parameter int LONG_MS    = 1000,
  parameter int REPEAT_MS  = 200,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [NUM_KEYS-1:0] key_i,
  output logic [NUM_KEYS-1:0] level_o,
  output logic [NUM_KEYS-1:0] press_o,
  output logic [NUM_KEYS-1:0] release_o,
  output logic [NUM_KEYS-1:0] long_o,
  output logic [NUM_KEYS-1:0] repeat_o
);

  localparam int TICK_CYCLES  = tick_cycles(CLK_FREQ, SAMPLE_MS);
  localparam int LONG_TICKS   = LONG_MS / SAMPLE_MS;
  localparam int REPEAT_TICKS = REPEAT_MS / SAMPLE_MS;
  localparam int TICK_W       = $clog2(TICK_CYCLES);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

  generate
    if (!params_legal(CLK_FREQ, NUM_KEYS, SAMPLE_MS, LONG_MS, REPEAT_MS)) begin : g_param_check
      $error("key_bank: illegal parameter combination");
    end
  endgenerate

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;

  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) tick_cnt_q <= '0;
    else         tick_cnt_q <= tick_cnt_d;
  end

  generate
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
      key_chan #(
        .LONG_TICKS   (LONG_TICKS),
        .REPEAT_TICKS (REPEAT_TICKS),
        .ACTIVE_LOW   (ACTIVE_LOW)
      ) u_chan (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .tick_i    (tick),
        .key_i     (key_i[k]),
        .level_o   (level_o[k]),
        .press_o   (press_o[k]),
        .release_o (release_o[k]),
        .long_o    (long_o[k]),
        .repeat_o  (repeat_o[k])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_key_bank.sv
`default_nettype none
// ============================================================================
// tb_key_bank : scoreboard bench for key_bank (10-cycle tick, long 10, repeat 3)
// Revision: 1.0
// ============================================================================
module tb_key_bank;

  localparam int N = 4;

  logic         clk  = 1'b0;
  logic         rstn = 1'b0;
  logic [N-1:0] key  = '1;
  logic [N-1:0] level, press, rel, lng, rpt;
  int           cyc      = 0;
  int           n_checks = 0;
  int           n_pass   = 0;

  typedef struct {
    int          cyc;
    logic [15:0] ev;
  } exp_t;

  exp_t sb[$];

  key_bank #(
    .CLK_FREQ   (1000),
    .NUM_KEYS   (N),
    .SAMPLE_MS  (10),
    .LONG_MS    (100),
    .REPEAT_MS  (30),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .key_i     (key),
    .level_o   (level),
    .press_o   (press),
    .release_o (rel),
    .long_o    (lng),
    .repeat_o  (rpt)
  );

  always #5 clk = ~clk;

  // Edges since the last reset release; ticks land on edges that are multiples of 10
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
  endtask

  task automatic expect_ev(input int c, input logic [3:0] p, input logic [3:0] r,
                           input logic [3:0] l, input logic [3:0] rp);
    exp_t e;
    e.cyc = c;
    e.ev  = {p, r, l, rp};
    sb.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rstn && (|{press, rel, lng, rpt})) begin
      if (sb.size() == 0) begin
        check("unexpected", 32'({press, rel, lng, rpt}), 32'h0);
      end else begin
        e = sb.pop_front();
        check("ev_cyc", cyc, e.cyc);
        check("ev_vec", 32'({press, rel, lng, rpt}), 32'(e.ev));
      end
    end
  end

  initial begin
    #60000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", 32'({level, press, rel, lng, rpt}), 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // 1: 5-cycle glitch reaches PCHK and is rejected
    goto(106); key[0] = 1'b0;
    goto(111); key[0] = 1'b1;
    goto(125); check("t1_level", 32'(level), 32'h0);
    goto(190); check("t1_drain", sb.size(), 0);

    // 2: short press, no long
    expect_ev(220, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    expect_ev(270, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    goto(200); key[1] = 1'b0;
    goto(230); check("t2_level_on", 32'(level), 32'h2);
    goto(250); key[1] = 1'b1;
    goto(280); check("t2_level_off", 32'(level), 32'h0);
    goto(290); check("t2_drain", sb.size(), 0);

    // 3: 200-cycle hold: long then three repeats
    expect_ev(320, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    expect_ev(420, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    expect_ev(450, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    expect_ev(480, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    expect_ev(510, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    expect_ev(520, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    goto(300); key[2] = 1'b0;
    goto(500); key[2] = 1'b1;
    goto(590); check("t3_drain", sb.size(), 0);

    // 4: two channels in the same cycle
    expect_ev(620, 4'b1001, 4'b0000, 4'b0000, 4'b0000);
    expect_ev(650, 4'b0000, 4'b1001, 4'b0000, 4'b0000);
    goto(600); key[0] = 1'b0; key[3] = 1'b0;
    goto(625); check("t4_level", 32'(level), 32'h9);
    goto(630); key[0] = 1'b1; key[3] = 1'b1;
    goto(690); check("t4_drain", sb.size(), 0);

    // 5: asynchronous reset after long, key still held
    expect_ev(720, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    expect_ev(820, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    goto(700); key[2] = 1'b0;
    goto(825); check("t5_pre_drain", sb.size(), 0);
    check("t5_level_held", 32'(level), 32'h4);
    #1 rstn = 1'b0;
    #1 check("t5_async_outs", 32'({level, press, rel, lng, rpt}), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    expect_ev(20,  4'b0100, 4'b0000, 4'b0000, 4'b0000);
    expect_ev(120, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    expect_ev(150, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    goto(130); key[2] = 1'b1;
    goto(190); check("t5_drain", sb.size(), 0);

    // 6: one-tick bounce mid-hold leaves long/repeat timing intact
    expect_ev(220, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    expect_ev(320, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    expect_ev(350, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    expect_ev(380, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    expect_ev(410, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    expect_ev(420, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    goto(200); key[1] = 1'b0;
    goto(250); key[1] = 1'b1;
    goto(260); key[1] = 1'b0;
    goto(265); check("t6_level_bounce", 32'(level), 32'h2);
    goto(400); key[1] = 1'b1;
    goto(470); check("t6_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
